// File: rtl/nios_adc_ocimem_pkg.sv
// Shared constants for the ocimem arbiter: FSM encodings, JTAG data-out field
// positions and the byte-lane merge used by the debug RAM.
package nios_adc_ocimem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_AV_RD = 2'd1;
    localparam logic [1:0] ST_JT_RD = 2'd2;

    localparam int JDO_W        = 38;
    localparam int JDO_ADDR_LSB = 2;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_RDQ_BIT  = 34;

    localparam logic [3:0] OCIMEM_BE_ALL = 4'hF;

    typedef enum logic {
        JOP_RD = 1'b0,
        JOP_WR = 1'b1
    } jop_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/nios_adc_cpu_ocimem_ram.sv
// Single-port debug RAM with byte enables and a registered read port
// (read-during-write returns the old word).
module nios_adc_cpu_ocimem_ram
    import nios_adc_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wren,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (wren)
            r_mem[addr] <= be_merge(r_mem[addr], wdata, byteen);
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/nios_adc_cpu_ocimem_arbiter.sv
// Arbitrates the single-port ocimem between the CPU Avalon debug slave and
// JTAG host commands; owns the JTAG monitor address/data registers.
module nios_adc_cpu_ocimem_arbiter
    import nios_adc_ocimem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_ready,
    output logic              cmd_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic [1:0]        r_state;
    logic              r_pending;
    jop_e              r_op;
    logic              r_last_jtag;
    logic [ADDR_W-1:0] r_mon_a;
    logic [31:0]       r_mon_d;
    logic              r_overrun;

    logic              w_av_req;
    logic              w_grant_av;
    logic              w_grant_jt;
    logic              w_jt_done;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic [31:0]       w_jdo_data;
    logic              w_jdo_rdq;
    logic [4:0]        w_unused_jdo;

    assign w_jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign w_jdo_data   = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    assign w_jdo_rdq    = jdo[JDO_RDQ_BIT];
    assign w_unused_jdo = {jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_ADDR_LSB-1:0]};

    assign w_av_req = avs_read | avs_write;

    // Grants are only issued from IDLE; on contention the round-robin
    // variant favours whoever was not served last.
    always_comb begin
        w_grant_av = 1'b0;
        w_grant_jt = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_av_req && r_pending) begin
                w_grant_av = (ROUND_ROBIN != 0) ? r_last_jtag : 1'b1;
                w_grant_jt = !w_grant_av;
            end else begin
                w_grant_av = w_av_req;
                w_grant_jt = r_pending;
            end
        end
    end

    assign w_jt_done = (w_grant_jt && r_op == JOP_WR) || (r_state == ST_JT_RD);

    always_comb begin
        ram_addr        = avs_address;
        ram_wren        = 1'b0;
        ram_byteen      = avs_byteenable;
        ram_wdata       = avs_writedata;
        avs_waitrequest = 1'b1;
        avs_readdata    = '0;
        if (reset_n) begin
            if (w_grant_av) begin
                if (avs_write) begin
                    ram_wren        = avs_debugaccess;
                    avs_waitrequest = 1'b0;
                end
            end else if (w_grant_jt) begin
                ram_addr   = r_mon_a;
                ram_byteen = OCIMEM_BE_ALL;
                ram_wdata  = r_mon_d;
                ram_wren   = (r_op == JOP_WR);
            end else if (r_state == ST_AV_RD) begin
                avs_readdata    = ram_rdata;
                avs_waitrequest = 1'b0;
            end else if (r_state == ST_JT_RD) begin
                ram_addr = r_mon_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_op        <= JOP_RD;
            r_last_jtag <= 1'b1;
            r_mon_a     <= '0;
            r_mon_d     <= '0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_av) begin
                        r_last_jtag <= 1'b0;
                        if (avs_read) r_state <= ST_AV_RD;
                    end else if (w_grant_jt) begin
                        r_last_jtag <= 1'b1;
                        if (r_op == JOP_RD) r_state <= ST_JT_RD;
                    end
                end
                ST_AV_RD: r_state <= ST_IDLE;
                ST_JT_RD: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_jt_done) begin
                r_mon_a   <= r_mon_a + ADDR_W'(1);
                r_pending <= 1'b0;
            end
            if (r_state == ST_JT_RD)
                r_mon_d <= ram_rdata;

            // New commands see the pending flag as it was at cycle start, so a
            // command landing on the completion cycle is still dropped. An
            // address load always lands and takes precedence over the increment.
            if (take_action_ocimem_b) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_mon_d   <= w_jdo_data;
                    r_pending <= 1'b1;
                    r_op      <= JOP_WR;
                end
            end else if (take_action_ocimem_a) begin
                r_mon_a <= w_jdo_addr;
                if (w_jdo_rdq && r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_overrun <= 1'b0;
                    if (w_jdo_rdq) begin
                        r_pending <= 1'b1;
                        r_op      <= JOP_RD;
                    end
                end
            end else if (take_no_action_ocimem_a) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                    r_op      <= JOP_RD;
                end
            end
        end
    end

    assign MonAReg     = r_mon_a;
    assign MonDReg     = r_mon_d;
    assign jtag_ready  = !r_pending;
    assign cmd_overrun = r_overrun;

endmodule

// File: tb/tb_nios_adc_cpu_ocimem_arbiter.sv
// Bench for the ocimem arbiter: directed Avalon table, JTAG corner sequences,
// then randomized traffic against a transaction-level memory/monitor model.
module tb_nios_adc_cpu_ocimem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] avs_address;
    logic          avs_read, avs_write, avs_debugaccess, avs_waitrequest;
    logic [31:0]   avs_writedata, avs_readdata;
    logic [3:0]    avs_byteenable;
    logic          take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0]   jdo;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          jtag_ready, cmd_overrun;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [3:0]    ram_byteen;
    logic [31:0]   ram_wdata, ram_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem [256];
    logic [7:0]  m_mon_a;
    logic [31:0] m_mon_d;
    logic        m_ovr;

    always #5 clk = ~clk;

    nios_adc_cpu_ocimem_arbiter #(.ADDR_W(AW), .ROUND_ROBIN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_debugaccess(avs_debugaccess), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata),
        .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a), .jdo(jdo),
        .MonDReg(MonDReg), .MonAReg(MonAReg), .jtag_ready(jtag_ready), .cmd_overrun(cmd_overrun),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    nios_adc_cpu_ocimem_ram #(.ADDR_W(AW)) u_ram (
        .clk(clk), .addr(ram_addr), .wren(ram_wren), .byteen(ram_byteen),
        .wdata(ram_wdata), .rdata(ram_rdata)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          dbg;
        logic [31:0] exp_rd;
        int          exp_waits;
    } av_vec_t;

    av_vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input bit rdq);
        logic [37:0] v;
        v = 38'(a) << 2;
        v[34] = rdq;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        return 38'(d) << 3;
    endfunction

    // Starts and ends at posedge+1; holds the request until !waitrequest.
    task automatic av_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit dbg,
                         output logic [31:0] rd, output int waits);
        bit done;
        done = 0; waits = 0; rd = '0;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        avs_debugaccess = dbg; avs_write = wr; avs_read = !wr;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                rd = avs_readdata;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("avalon_timeout", 32'(waits), 32'd0);
        avs_read = 0; avs_write = 0;
    endtask

    task automatic av_do(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit dbg,
                         output logic [31:0] rd, output int waits);
        av_op(wr, a, d, be, dbg, rd, waits);
        if (wr && dbg)
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic wait_ready();
        bit done;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (jtag_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("jtag_ready_timeout", 32'(jtag_ready), 32'd1);
    endtask

    // kind 0: ocimem_a, 1: ocimem_b, 2: no_action_a
    task automatic jt_pulse(input int kind, input logic [7:0] a, input bit rdq, input logic [31:0] d);
        case (kind)
            0:       begin jdo = jdo_a(a, rdq); take_action_ocimem_a = 1; end
            1:       begin jdo = jdo_b(d);      take_action_ocimem_b = 1; end
            default: begin jdo = '0;            take_no_action_ocimem_a = 1; end
        endcase
        @(posedge clk); #1;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    endtask

    task automatic jt_cmd(input int kind, input logic [7:0] a, input bit rdq, input logic [31:0] d);
        jt_pulse(kind, a, rdq, d);
        wait_ready();
        case (kind)
            0: begin
                m_mon_a = a; m_ovr = 0;
                if (rdq) begin m_mon_d = model_mem[m_mon_a]; m_mon_a++; end
            end
            1:       begin m_mon_d = d; model_mem[m_mon_a] = d; m_mon_a++; end
            default: begin m_mon_d = model_mem[m_mon_a]; m_mon_a++; end
        endcase
        chk("jtag_MonAReg", 32'(MonAReg), 32'(m_mon_a));
        chk("jtag_MonDReg", MonDReg, m_mon_d);
        chk("jtag_overrun", 32'(cmd_overrun), 32'(m_ovr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          waits;

        tbl[0] = '{1, 8'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0,          0};
        tbl[1] = '{0, 8'h10, 32'h0,        4'hF, 1, 32'hDEADBEEF,   1};
        tbl[2] = '{1, 8'h11, 32'h11223344, 4'h5, 1, 32'h0,          0};
        tbl[3] = '{0, 8'h11, 32'h0,        4'hF, 1, 32'hA5220044,   1};
        tbl[4] = '{1, 8'h20, 32'hCAFEF00D, 4'hF, 0, 32'h0,          0};
        tbl[5] = '{0, 8'h20, 32'h0,        4'hF, 1, 32'hA5A50020,   1};
        tbl[6] = '{1, 8'h12, 32'hFFFFFFFF, 4'h0, 1, 32'h0,          0};
        tbl[7] = '{0, 8'h12, 32'h0,        4'hF, 1, 32'hA5A50012,   1};
        tbl[8] = '{1, 8'h13, 32'h99887766, 4'h8, 1, 32'h0,          0};
        tbl[9] = '{0, 8'h13, 32'h0,        4'hF, 1, 32'h99A50013,   1};

        reset_n = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        avs_byteenable = '0; avs_debugaccess = 0;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        jdo = '0;
        m_mon_a = '0; m_mon_d = '0; m_ovr = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
        chk("rst_jtag_ready", 32'(jtag_ready), 32'd1);
        chk("rst_MonAReg", 32'(MonAReg), 32'd0);
        chk("rst_MonDReg", MonDReg, 32'd0);
        chk("rst_overrun", 32'(cmd_overrun), 32'd0);
        chk("rst_ram_wren", 32'(ram_wren), 32'd0);
        reset_n = 1;
        @(posedge clk); #1;

        for (int a = 0; a < 256; a++)
            av_do(1, 8'(a), 32'hA5A5_0000 | 32'(a), 4'hF, 1, rd, waits);

        // Avalon directed table
        for (int i = 0; i < 10; i++) begin
            av_do(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].dbg, rd, waits);
            chk($sformatf("tbl%0d_waits", i), 32'(waits), 32'(tbl[i].exp_waits));
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // JTAG address wrap across 8'hFF
        jt_cmd(0, 8'hFF, 0, 32'h0);
        jt_cmd(1, 8'h00, 0, 32'h1234_5678);
        jt_cmd(1, 8'h00, 0, 32'h1234_5678);
        chk("wrap_MonAReg", 32'(MonAReg), 32'h01);
        av_do(0, 8'hFF, 32'h0, 4'hF, 1, rd, waits);
        chk("wrap_ram_ff", rd, 32'h1234_5678);
        av_do(0, 8'h00, 32'h0, 4'hF, 1, rd, waits);
        chk("wrap_ram_00", rd, 32'h1234_5678);

        // Contention with JTAG served last: Avalon goes first
        jt_cmd(0, 8'h05, 1, 32'h0);
        chk("rd05_MonDReg", MonDReg, 32'hA5A50005);
        jt_pulse(2, 8'h0, 0, 32'h0);
        av_do(0, 8'h10, 32'h0, 4'hF, 1, rd, waits);
        chk("rr_av_first_waits", 32'(waits), 32'd1);
        chk("rr_av_first_rdata", rd, 32'hDEADBEEF);
        wait_ready();
        chk("rr_jt_next_MonDReg", MonDReg, 32'hA5A50006);
        chk("rr_jt_next_MonAReg", 32'(MonAReg), 32'h07);

        // Back-to-back read commands: second is dropped
        take_no_action_ocimem_a = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 0;
        wait_ready();
        chk("ovr_flag", 32'(cmd_overrun), 32'd1);
        chk("ovr_one_read_MonAReg", 32'(MonAReg), 32'h08);
        chk("ovr_MonDReg", MonDReg, 32'hA5A50007);
        m_mon_a = 8'h08; m_mon_d = 32'hA5A50007; m_ovr = 1;
        jt_cmd(0, 8'h30, 0, 32'h0);
        chk("ovr_cleared", 32'(cmd_overrun), 32'd0);

        // Reset while in AV_RD with a JTAG read pending
        jt_pulse(2, 8'h0, 0, 32'h0);
        avs_address = 8'h10; avs_read = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_avrd_wait", 32'(avs_waitrequest), 32'd0);
        chk("mid_pending", 32'(jtag_ready), 32'd0);
        reset_n = 0;
        #1;
        chk("mid_rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("mid_rst_wren", 32'(ram_wren), 32'd0);
        chk("mid_rst_ready", 32'(jtag_ready), 32'd1);
        chk("mid_rst_MonAReg", 32'(MonAReg), 32'd0);
        avs_read = 0;
        @(posedge clk); #1;
        reset_n = 1;
        m_mon_a = '0; m_mon_d = '0; m_ovr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_read", 32'(MonAReg), 32'd0);
        chk("post_rst_MonDReg", MonDReg, 32'd0);
        chk("post_rst_ram_10", model_mem[8'h10], 32'hDEADBEEF);

        // Contention with Avalon served last: JTAG goes first
        av_do(1, 8'h40, 32'h0BADF00D, 4'hF, 1, rd, waits);
        jt_pulse(2, 8'h0, 0, 32'h0);
        av_do(0, 8'h40, 32'h0, 4'hF, 1, rd, waits);
        chk("rr_jt_first_waits", 32'(waits), 32'd3);
        chk("rr_jt_first_rdata", rd, 32'h0BADF00D);
        chk("rr_jt_first_MonDReg", MonDReg, 32'h1234_5678);
        chk("rr_jt_first_MonAReg", 32'(MonAReg), 32'd1);
        m_mon_a = 8'h01; m_mon_d = 32'h1234_5678;

        // Randomized serial traffic
        for (int it = 0; it < 200; it++) begin
            int          op;
            logic [7:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 4);
            a  = 8'($urandom);
            d  = $urandom;
            case (op)
                0: begin
                    av_do(1, a, d, 4'($urandom), ($urandom_range(0, 3) != 0), rd, waits);
                    chk("rnd_wr_waits", 32'(waits), 32'd0);
                end
                1: begin
                    av_do(0, a, 32'h0, 4'hF, 1, rd, waits);
                    chk("rnd_rd_waits", 32'(waits), 32'd1);
                    chk("rnd_rd_data", rd, model_mem[a]);
                end
                2:       jt_cmd(0, a, 1'($urandom), 32'h0);
                3:       jt_cmd(1, 8'h0, 0, d);
                default: jt_cmd(2, 8'h0, 0, 32'h0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
